// File: rtl/ram_burst_master.sv
// ram_burst_master: burst sequencer in front of the 64x64 data-memory RAM.
// Turns one burst command into single-word RAM reads/writes with streams.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   cmd_*             burst command (valid/ready, write flag, addr, len)
//   wr_data/valid/rdy write-data stream into the RAM
//   rd_data/valid/rdy read-data stream out of the RAM
//   done, err         burst-complete and command-rejected pulses
//   address, enable_read, enable_write, DMin, DMout   RAM side
//
// Optional feature macro: RAM_BURST_MASTER_RANGECHK_EN
//   defined   -> reject len==0, len>DEPTH, addr>=DEPTH with an err pulse
//   undefined -> addr and len taken modulo DEPTH, len 0 means DEPTH words
module ram_burst_master #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] address,
    output logic              enable_read,
    output logic              enable_write,
    output logic [DATA_W-1:0] DMin,
    input  logic [DATA_W-1:0] DMout
);

    localparam int          CNT_W   = $clog2(DEPTH + 1);
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_CAP,
        RD_HOLD,
        WR_ACCEPT,
        WR_ISSUE,
        FIN
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [ADDR_W-1:0]  address_q;
    logic               enable_read_q;
    logic               enable_write_q;
    logic [DATA_W-1:0]  dmin_q;
    logic [DATA_W-1:0]  rd_data_q;
    logic               rd_valid_q;
    logic               wr_ready_q;
    logic               done_q;

    logic [31:0]        addr_ext;
    logic [31:0]        len_ext;
    logic [ADDR_W-1:0]  start_addr;
    logic [CNT_W-1:0]   start_cnt;
    logic               cmd_bad;
    logic               cmd_hs;
    logic [ADDR_W-1:0]  addr_inc;
    logic               cnt_last;

    assign addr_ext = 32'(cmd_addr);
    assign len_ext  = 32'(cmd_len);
    assign cmd_hs   = cmd_valid && (state_q == IDLE);

`ifdef RAM_BURST_MASTER_RANGECHK_EN
    // Out-of-range commands never reach the RAM; in-range ones fit as-is.
    assign cmd_bad    = (len_ext == 32'd0) || (len_ext > DEPTH_U) ||
                        (addr_ext >= DEPTH_U);
    assign start_addr = ADDR_W'(addr_ext % DEPTH_U);
    assign start_cnt  = CNT_W'(len_ext);
`else
    logic [31:0] len_mod;

    assign cmd_bad    = 1'b0;
    assign len_mod    = len_ext % DEPTH_U;
    assign start_addr = ADDR_W'(addr_ext % DEPTH_U);
    // A zero residue stands for a full-memory burst.
    assign start_cnt  = (len_mod == 32'd0) ? CNT_W'(DEPTH) : CNT_W'(len_mod);
`endif

    assign addr_inc = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
    assign cnt_last = (cnt_q == CNT_W'(1));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d = start_addr;
                    cnt_d  = start_cnt;
                    if (!cmd_bad) begin
                        state_d = cmd_write ? WR_ACCEPT : RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: state_d = RD_CAP;
            RD_CAP:   state_d = RD_HOLD;
            RD_HOLD: begin
                if (rd_ready) begin
                    addr_d  = addr_inc;
                    cnt_d   = cnt_q - 1'b1;
                    state_d = cnt_last ? FIN : RD_ISSUE;
                end
            end
            WR_ACCEPT: begin
                if (wr_valid) begin
                    state_d = WR_ISSUE;
                end
            end
            WR_ISSUE: begin
                addr_d  = addr_inc;
                cnt_d   = cnt_q - 1'b1;
                state_d = cnt_last ? FIN : WR_ACCEPT;
            end
            FIN:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stream/RAM outputs are registered from the next state so they are
    // glitch-free and line up with the state they belong to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            address_q      <= '0;
            enable_read_q  <= 1'b0;
            enable_write_q <= 1'b0;
            dmin_q         <= '0;
            rd_data_q      <= '0;
            rd_valid_q     <= 1'b0;
            wr_ready_q     <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            enable_read_q  <= (state_d == RD_ISSUE);
            enable_write_q <= (state_d == WR_ISSUE);
            rd_valid_q     <= (state_d == RD_HOLD);
            wr_ready_q     <= (state_d == WR_ACCEPT);
            done_q         <= (state_d == FIN);
            if ((state_d == RD_ISSUE) || (state_d == WR_ISSUE)) begin
                address_q <= addr_d;
            end
            if ((state_q == WR_ACCEPT) && wr_valid) begin
                dmin_q <= wr_data;
            end
            // RAM output is registered, so it is valid one cycle after issue.
            if (state_q == RD_CAP) begin
                rd_data_q <= DMout;
            end
        end
    end

`ifdef RAM_BURST_MASTER_RANGECHK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= cmd_hs && cmd_bad;
        end
    end

    assign err = err_q;
`else
    logic unused_hs;

    assign unused_hs = cmd_hs;
    assign err       = 1'b0;
`endif

    assign cmd_ready    = (state_q == IDLE);
    assign wr_ready     = wr_ready_q;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign done         = done_q;
    assign address      = address_q;
    assign enable_read  = enable_read_q;
    assign enable_write = enable_write_q;
    assign DMin         = dmin_q;

endmodule
